// File: rtl/tm_pkg.sv
// ---------------------------------------------------------------------------
// Module : tm_pkg
// Desc   : Shared constants and the argmax FSM state type for the Tsetlin
//          Machine inference datapath.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tm_pkg;

    localparam int TM_NUM_CLASSES = 10;
    localparam int TM_SUM_W       = 32;
    localparam int THRESHOLD_POS  = 50;
    localparam int THRESHOLD_NEG  = -50;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } argmax_state_e;

endpackage : tm_pkg

`default_nettype wire

// File: rtl/class_argmax_seq_cmp.sv
// ---------------------------------------------------------------------------
// Module : class_cmp_sel
// Desc   : Combinational running-max selector: first beat loads, later beats
//          replace only on a strictly greater signed sum.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module class_cmp_sel
    import tm_pkg::*;
#(
    parameter int SUM_W = TM_SUM_W,
    parameter int IDX_W = 4
) (
    input  logic                    first_i,
    input  logic signed [SUM_W-1:0] sum_i,
    input  logic        [IDX_W-1:0] cnt_i,
    input  logic signed [SUM_W-1:0] best_sum_i,
    input  logic        [IDX_W-1:0] best_idx_i,
    output logic signed [SUM_W-1:0] best_sum_o,
    output logic        [IDX_W-1:0] best_idx_o
);

    always_comb begin
        best_sum_o = best_sum_i;
        best_idx_o = best_idx_i;
        // Strict compare keeps the lower index on ties.
        if (first_i) begin
            best_sum_o = sum_i;
            best_idx_o = '0;
        end else if (sum_i > best_sum_i) begin
            best_sum_o = sum_i;
            best_idx_o = cnt_i;
        end
    end

endmodule : class_cmp_sel

`default_nettype wire

// File: rtl/class_argmax_seq.sv
// ---------------------------------------------------------------------------
// Module : class_argmax_seq
// Desc   : Serial argmax over NUM_CLASSES clamped class sums; reports the
//          winning class index and its sum.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module class_argmax_seq
    import tm_pkg::*;
#(
    parameter int NUM_CLASSES = TM_NUM_CLASSES,
    parameter int SUM_W       = TM_SUM_W,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                    clk,
    input  logic                    rst_flag,
    input  logic                    start,
    input  logic                    stop_flag,
    input  logic                    sum_valid,
    input  logic signed [SUM_W-1:0] sum_in,
    output logic                    sum_ready,
    output logic                    busy,
    output logic                    pred_valid,
    output logic        [IDX_W-1:0] pred_class,
    output logic signed [SUM_W-1:0] pred_sum
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_e            state_q;
    logic         [IDX_W-1:0] cnt_q;
    logic         [IDX_W-1:0] best_idx_q;
    logic signed  [SUM_W-1:0] best_sum_q;
    logic         [IDX_W-1:0] pred_class_q;
    logic signed  [SUM_W-1:0] pred_sum_q;

    logic         [IDX_W-1:0] best_idx_d;
    logic signed  [SUM_W-1:0] best_sum_d;
    logic                     accept;

    assign sum_ready  = (state_q == ST_COLLECT) && !stop_flag;
    assign accept     = sum_valid && sum_ready;
    assign busy       = (state_q != ST_IDLE);
    // A DONE pulse that coincides with a freeze is held off until it lifts.
    assign pred_valid = (state_q == ST_DONE) && !stop_flag;
    assign pred_class = pred_class_q;
    assign pred_sum   = pred_sum_q;

    class_cmp_sel #(
        .SUM_W (SUM_W),
        .IDX_W (IDX_W)
    ) u_cmp_sel (
        .first_i    (cnt_q == '0),
        .sum_i      (sum_in),
        .cnt_i      (cnt_q),
        .best_sum_i (best_sum_q),
        .best_idx_i (best_idx_q),
        .best_sum_o (best_sum_d),
        .best_idx_o (best_idx_d)
    );

    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            best_idx_q   <= '0;
            best_sum_q   <= '0;
            pred_class_q <= '0;
            pred_sum_q   <= '0;
        end else if (!stop_flag) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (start) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        best_sum_q <= best_sum_d;
                        best_idx_q <= best_idx_d;
                        if (cnt_q == LAST_IDX) begin
                            // Result is captured with the final beat folded in.
                            state_q      <= ST_DONE;
                            cnt_q        <= '0;
                            pred_class_q <= best_idx_d;
                            pred_sum_q   <= best_sum_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= start ? ST_COLLECT : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule : class_argmax_seq

`default_nettype wire

// File: tb/tb_class_argmax_seq.sv
// ---------------------------------------------------------------------------
// Module : tb_class_argmax_seq
// Desc   : Scoreboard bench for class_argmax_seq with directed sum streams.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_class_argmax_seq;

    localparam int NC = 10;
    localparam int SW = 32;
    localparam int IW = $clog2(NC);

    logic                 clk;
    logic                 rst_flag;
    logic                 start;
    logic                 stop_flag;
    logic                 sum_valid;
    logic signed [SW-1:0] sum_in;
    logic                 sum_ready;
    logic                 busy;
    logic                 pred_valid;
    logic        [IW-1:0] pred_class;
    logic signed [SW-1:0] pred_sum;

    class_argmax_seq #(
        .NUM_CLASSES (NC),
        .SUM_W       (SW),
        .IDX_W       (IW)
    ) dut (
        .clk        (clk),
        .rst_flag   (rst_flag),
        .start      (start),
        .stop_flag  (stop_flag),
        .sum_valid  (sum_valid),
        .sum_in     (sum_in),
        .sum_ready  (sum_ready),
        .busy       (busy),
        .pred_valid (pred_valid),
        .pred_class (pred_class),
        .pred_sum   (pred_sum)
    );

    typedef struct {
        int cls;
        int sum;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pv_count = 0;

    int s_basic[10] = '{3, -7, 12, 50, 0, -50, 49, 1, 2, 4};
    int s_eq50[10]  = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50};
    int s_tie17[10] = '{1, 2, 17, -5, 16, 0, 3, 17, 9, -17};
    int s_neg50[10] = '{-50, -50, -50, -50, -50, -50, -50, -50, -50, -50};
    int s_last[10]  = '{-50, -50, -50, -50, -50, -50, -50, -50, -50, 7};
    int s_abort[10] = '{-10, -20, -30, -40, -50, -9, -8, -7, -4, -3};
    int s_b2b[10]   = '{-50, -50, -50, -50, -50, -50, 20, -50, -50, -50};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int cls, input int sum);
        exp_t e;
        e.cls = cls;
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    // Monitor: every pred_valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            exp_t e;
            pv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_pred_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pred_class", {{(64-IW){1'b0}}, pred_class}, e.cls);
                check("pred_sum", pred_sum, e.sum);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input int v);
        logic ok;
        ok        = 1'b0;
        sum_valid = 1'b1;
        sum_in    = v;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = sum_ready;
            tick();
        end
        sum_valid = 1'b0;
        if (!ok) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic send_stream(input int v[10]);
        for (int i = 0; i < 10; i++) send_beat(v[i]);
    endtask

    task automatic expect_done();
        @(negedge clk);
        check("pred_valid_latency", pred_valid, 1);
        tick();
    endtask

    initial begin
        int pv0;
        rst_flag  = 1'b1;
        start     = 1'b0;
        stop_flag = 1'b0;
        sum_valid = 1'b0;
        sum_in    = '0;
        repeat (2) @(negedge clk);
        check("rst_sum_ready", sum_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_class", {{(64-IW){1'b0}}, pred_class}, 0);
        check("rst_pred_sum", pred_sum, 0);
        tick();
        rst_flag = 1'b0;
        tick();

        // Idle: sum_valid ignored
        sum_valid = 1'b1;
        sum_in    = 33;
        @(negedge clk);
        check("idle_sum_ready", sum_ready, 0);
        tick();
        sum_valid = 1'b0;

        push_exp(3, 50);
        pulse_start();
        send_stream(s_basic);
        expect_done();

        push_exp(0, 50);
        pulse_start();
        send_stream(s_eq50);
        expect_done();

        push_exp(2, 17);
        pulse_start();
        send_stream(s_tie17);
        expect_done();

        push_exp(0, -50);
        pulse_start();
        send_stream(s_neg50);
        expect_done();

        // Gaps plus a 3-cycle freeze with a beat pending
        push_exp(3, 50);
        pulse_start();
        send_beat(3);
        send_beat(-7);
        repeat (2) tick();
        send_beat(12);
        tick();
        send_beat(50);
        send_beat(0);
        sum_valid = 1'b1;
        sum_in    = -50;
        stop_flag = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stop_sum_ready", sum_ready, 0);
            check("stop_busy", busy, 1);
            tick();
        end
        stop_flag = 1'b0;
        send_beat(-50);
        send_beat(49);
        send_beat(1);
        tick();
        send_beat(2);
        send_beat(4);
        expect_done();

        // Freeze during DONE defers the pulse
        push_exp(9, 7);
        pulse_start();
        send_stream(s_last);
        stop_flag = 1'b1;
        @(negedge clk);
        check("stop_done_pv0", pred_valid, 0);
        tick();
        @(negedge clk);
        check("stop_done_pv1", pred_valid, 0);
        check("stop_done_busy", busy, 1);
        tick();
        stop_flag = 1'b0;
        expect_done();

        // Start mid-collect aborts; only the restarted run reports
        pv0 = pv_count;
        push_exp(9, -3);
        pulse_start();
        repeat (4) send_beat(40);
        pulse_start();
        send_stream(s_abort);
        expect_done();
        repeat (2) tick();
        check("abort_one_pulse", pv_count - pv0, 1);

        // Reset mid-collect discards the partial result
        pv0 = pv_count;
        pulse_start();
        repeat (5) send_beat(45);
        rst_flag = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum_ready", sum_ready, 0);
        check("mid_rst_pred_valid", pred_valid, 0);
        check("mid_rst_pred_class", {{(64-IW){1'b0}}, pred_class}, 0);
        check("mid_rst_pred_sum", pred_sum, 0);
        tick();
        rst_flag = 1'b0;
        repeat (15) tick();
        check("mid_rst_no_pulse", pv_count - pv0, 0);

        // Back-to-back: start in the DONE cycle
        pv0 = pv_count;
        push_exp(3, 50);
        push_exp(6, 20);
        pulse_start();
        send_stream(s_basic);
        pulse_start();
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_sum_ready", sum_ready, 1);
        tick();
        for (int i = 0; i < 5; i++) send_beat(s_b2b[i]);
        @(negedge clk);
        check("b2b_hold_class", {{(64-IW){1'b0}}, pred_class}, 3);
        tick();
        for (int i = 5; i < 10; i++) send_beat(s_b2b[i]);
        expect_done();
        repeat (3) tick();
        check("b2b_two_pulses", pv_count - pv0, 2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_class_argmax_seq

`default_nettype wire

// File: doc/class_argmax_seq.md
Name: class_argmax_seq

Overview:
- Final decision stage of the Tsetlin Machine inference datapath.
- Sits directly downstream of the per-class clamp stage and consumes one clamped signed class sum per accepted beat.
- Over NUM_CLASSES beats it tracks the running maximum and reports the winning class index and its sum.
- Serial, so one comparator serves any class count.

Parameters:
- NUM_CLASSES, 10: number of class sums per inference (>=2).
- SUM_W, 32: signed width of incoming class sums.
- IDX_W, $clog2(NUM_CLASSES): width of class index and beat counter.

Ports:
- clk  in  1  clock.
- rst_flag  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a new inference.
- stop_flag  in  1  freeze; when high, all state holds and sum_ready=0.
- sum_valid  in  1  sum_in valid.
- sum_in  in  SUM_W  signed clamped class sum; class index is implied by arrival order (0 first).
- sum_ready  out  1  block can accept a sum this cycle.
- busy  out  1  FSM not in IDLE.
- pred_valid  out  1  one-cycle pulse: result available.
- pred_class  out  IDX_W  winning class index.
- pred_sum  out  SUM_W  signed sum of winning class.

Behaviour:
- Reset (async, rst_flag=1): state=IDLE; cnt, best_idx, best_sum, pred_class, pred_sum = 0; pred_valid=0, sum_ready=0, busy=0. Applies mid-COLLECT too: the partial result is discarded and no pred_valid is produced.
- FSM states:
  - IDLE: sum_ready=0; sum_valid is ignored. start (with stop_flag=0) -> COLLECT, cnt=0.
  - COLLECT: sum_ready = !stop_flag. Accept = sum_valid & sum_ready.
    - Beat with cnt==0: load best_sum=sum_in, best_idx=0 unconditionally.
    - Later beats: if sum_in > best_sum (strict signed compare), load best_sum=sum_in, best_idx=cnt.
    - Ties keep the lower index.
    - cnt increments per accept. The accept with cnt==NUM_CLASSES-1 -> DONE; the compare includes this final beat.
  - DONE (1 cycle): pred_valid=1; pred_class/pred_sum are registered from best_idx/best_sum in the same cycle. Next state IDLE, or COLLECT if start=1 in this cycle.
- Latency: pred_valid is high exactly 1 cycle after the final accept. Minimum inference is NUM_CLASSES+1 cycles from the first accept.
- pred_class/pred_sum hold their value until the next DONE; they are not cleared by start.
- start during COLLECT: abort and restart; cnt=0, the next accept is treated as class 0, and there is no pred_valid for the aborted run.
- stop_flag=1: freezes state, cnt and best registers in every state. A start pulse while stop_flag=1 is ignored. If the DONE pulse is due, it is deferred until stop_flag falls.
- sum_valid gaps within COLLECT are legal; only accepts advance cnt.
- busy=1 in COLLECT and DONE.

Decomposition:
- Shared package tm_pkg:
  - NUM_CLASSES, SUM_W, THRESHOLD_POS/NEG (+50/-50) constants.
  - argmax FSM state enum (IDLE, COLLECT, DONE).
- One natural sub-module: class_cmp_sel, combinational. Inputs: first-beat flag, sum_in, cnt, best_sum, best_idx. Outputs: next best_sum and next best_idx (strict greater-than, first-beat load).

Test Plan:
- Basic: start; sums 3,-7,12,50,0,-50,49,1,2,4 back-to-back -> pred_valid 1 cycle after 10th accept; pred_class=3, pred_sum=50.
- Ties:
  - All ten sums = 50 -> class 0, sum 50.
  - Sums with 17 at classes 2 and 7, others <17 -> class 2.
- All negative: all sums = -50 -> class 0, pred_sum=-50. Also checks that the first beat loads rather than compares against a 0 initial value.
- Backpressure and freeze:
  - Same stream as Basic, with sum_valid idle gaps and stop_flag high for 3 cycles mid-stream.
  - During stop_flag: sum_ready=0, and no beats are consumed while stop_flag=1.
  - Result: class 3 / 50.
  - stop_flag high in the DONE cycle delays pred_valid.
- Abort/reset:
  - start again after 4 accepts, then 10 new sums with max -3 at class 9 -> class 9, sum -3, exactly one pred_valid.
  - Separately, rst_flag mid-COLLECT -> all outputs 0, no pred_valid.
- Back-to-back: start asserted in the DONE cycle -> next inference begins with no IDLE cycle; previous pred_class holds until the second pred_valid.
